// File: rtl/spi_slave_responder_if.sv
// Bus bundle between the SPI slave responder and its surroundings: the
// serial pins from the remote master plus the local register-side handshake.
interface spi_slave_responder_if;
    logic       spe_i;
    logic       cpol_i;
    logic       cpha_i;
    logic       lsbfe_i;
    logic       ss_n_i;
    logic       sclk_i;
    logic       mosi_i;
    logic       miso_o;
    logic       miso_oe_o;
    logic [7:0] tx_data_i;
    logic       tx_load_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ack_i;
    logic       overrun_o;
    logic       underrun_o;
    logic       status_clr_i;
    logic       busy_o;

    modport slave (
        input  spe_i, cpol_i, cpha_i, lsbfe_i, ss_n_i, sclk_i, mosi_i,
               tx_data_i, tx_load_i, rx_ack_i, status_clr_i,
        output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
               overrun_o, underrun_o, busy_o
    );

    modport master (
        output spe_i, cpol_i, cpha_i, lsbfe_i, ss_n_i, sclk_i, mosi_i,
               tx_data_i, tx_load_i, rx_ack_i, status_clr_i,
        input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
               overrun_o, underrun_o, busy_o
    );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI slave responder: oversamples SS/SCLK/MOSI in the PCLK domain, receives
// bytes into rx_data_o and shifts bytes from a one-entry buffer out on MISO.
module spi_slave_responder #(
    parameter int SYNC_STAGES = 2
) (
    input logic                  PCLK,
    input logic                  PRESET,
    spi_slave_responder_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_d_r;
    logic                   cpol_r;
    logic                   cpha_r;
    logic                   lsbfe_r;
    logic                   first_shift_r;
    logic [3:0]             bit_cnt_r;
    logic [7:0]             tx_buf_r;
    logic [7:0]             tx_shift_r;
    logic [7:0]             rx_shift_r;
    logic [7:0]             rx_data_r;
    logic                   tx_ready_r;
    logic                   rx_valid_r;
    logic                   overrun_r;
    logic                   underrun_r;
    logic                   busy_r;
    logic                   miso_r;
    logic                   miso_oe_r;

    logic       ss_s;
    logic       sclk_s;
    logic       mosi_s;
    logic       lead_s;
    logic       trail_s;
    logic       start_s;
    logic       abort_s;
    logic       run_s;
    logic       sample_s;
    logic       shift_s;
    logic       skip_s;
    logic       reload_s;
    logic       step_s;
    logic       complete_s;
    logic       rx_take_s;
    logic       overrun_set_s;
    logic       underrun_set_s;
    logic       reload_empty_s;
    logic [7:0] reload_byte_s;
    logic [7:0] rx_next_s;
    logic [7:0] tx_next_s;

    function automatic logic out_bit(input logic [7:0] v, input logic lsb_first);
        return lsb_first ? v[0] : v[7];
    endfunction

    assign bus.miso_o     = miso_r;
    assign bus.miso_oe_o  = miso_oe_r;
    assign bus.tx_ready_o = tx_ready_r;
    assign bus.rx_data_o  = rx_data_r;
    assign bus.rx_valid_o = rx_valid_r;
    assign bus.overrun_o  = overrun_r;
    assign bus.underrun_o = underrun_r;
    assign bus.busy_o     = busy_r;

    // Synchronizers for the asynchronous bus pins plus the SCLK edge-detect flop.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ss_sync_r   <= {SYNC_STAGES{1'b1}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_d_r    <= 1'b0;
        end else begin
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], bus.ss_n_i};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.sclk_i};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.mosi_i};
            sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
        end
    end

    // Edge classification, event decode and next-value datapath.
    always_comb begin
        ss_s    = ss_sync_r[SYNC_STAGES-1];
        sclk_s  = sclk_sync_r[SYNC_STAGES-1];
        mosi_s  = mosi_sync_r[SYNC_STAGES-1];
        lead_s  = (sclk_d_r == cpol_r) && (sclk_s != cpol_r);
        trail_s = (sclk_d_r != cpol_r) && (sclk_s == cpol_r);

        start_s    = (state_r == ST_IDLE) && !ss_s && bus.spe_i;
        abort_s    = (state_r == ST_ACTIVE) && (ss_s || !bus.spe_i);
        run_s      = (state_r == ST_ACTIVE) && !abort_s;
        sample_s   = run_s && (cpha_r ? trail_s : lead_s) && (bit_cnt_r != 4'd8);
        shift_s    = run_s && (cpha_r ? lead_s : trail_s);
        // With CPHA=1 the first leading edge only opens the byte; bit 7/0 is already out.
        skip_s     = shift_s && cpha_r && first_shift_r;
        reload_s   = start_s || (shift_s && !skip_s && (bit_cnt_r == 4'd8));
        step_s     = shift_s && !skip_s && (bit_cnt_r != 4'd8);
        complete_s = sample_s && (bit_cnt_r == 4'd7);

        // A load coinciding with an empty-buffer reload goes straight to the shifter.
        if (!tx_ready_r) begin
            reload_byte_s  = tx_buf_r;
            reload_empty_s = 1'b0;
        end else if (bus.tx_load_i) begin
            reload_byte_s  = bus.tx_data_i;
            reload_empty_s = 1'b0;
        end else begin
            reload_byte_s  = 8'h00;
            reload_empty_s = 1'b1;
        end

        rx_next_s      = lsbfe_r ? {mosi_s, rx_shift_r[7:1]} : {rx_shift_r[6:0], mosi_s};
        tx_next_s      = lsbfe_r ? {1'b0, tx_shift_r[7:1]} : {tx_shift_r[6:0], 1'b0};
        rx_take_s      = complete_s && (!rx_valid_r || bus.rx_ack_i);
        overrun_set_s  = complete_s && !rx_take_s;
        underrun_set_s = reload_s && reload_empty_s;
    end

    // Transfer FSM with transmit buffer, receive register and sticky status.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r       <= ST_IDLE;
            cpol_r        <= 1'b0;
            cpha_r        <= 1'b0;
            lsbfe_r       <= 1'b0;
            first_shift_r <= 1'b0;
            bit_cnt_r     <= 4'd0;
            tx_buf_r      <= 8'h00;
            tx_shift_r    <= 8'h00;
            rx_shift_r    <= 8'h00;
            rx_data_r     <= 8'h00;
            tx_ready_r    <= 1'b1;
            rx_valid_r    <= 1'b0;
            overrun_r     <= 1'b0;
            underrun_r    <= 1'b0;
            busy_r        <= 1'b0;
            miso_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
        end else begin
            if (reload_s) begin
                tx_ready_r <= 1'b1;
            end else if (bus.tx_load_i && tx_ready_r) begin
                tx_buf_r   <= bus.tx_data_i;
                tx_ready_r <= 1'b0;
            end

            overrun_r  <= overrun_set_s || (overrun_r && !bus.status_clr_i);
            underrun_r <= underrun_set_s || (underrun_r && !bus.status_clr_i);

            if (rx_take_s) begin
                rx_data_r  <= rx_next_s;
                rx_valid_r <= 1'b1;
            end else if (bus.rx_ack_i) begin
                rx_valid_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r       <= ST_ACTIVE;
                        busy_r        <= 1'b1;
                        cpol_r        <= bus.cpol_i;
                        cpha_r        <= bus.cpha_i;
                        lsbfe_r       <= bus.lsbfe_i;
                        tx_shift_r    <= reload_byte_s;
                        miso_r        <= out_bit(reload_byte_s, bus.lsbfe_i);
                        miso_oe_r     <= 1'b1;
                        bit_cnt_r     <= 4'd0;
                        first_shift_r <= 1'b1;
                        rx_shift_r    <= 8'h00;
                    end
                end
                ST_ACTIVE: begin
                    if (abort_s) begin
                        state_r       <= ST_IDLE;
                        busy_r        <= 1'b0;
                        miso_r        <= 1'b0;
                        miso_oe_r     <= 1'b0;
                        bit_cnt_r     <= 4'd0;
                        first_shift_r <= 1'b0;
                        rx_shift_r    <= 8'h00;
                    end else begin
                        if (sample_s) begin
                            rx_shift_r <= rx_next_s;
                            bit_cnt_r  <= bit_cnt_r + 4'd1;
                        end
                        if (skip_s) begin
                            first_shift_r <= 1'b0;
                        end else if (reload_s) begin
                            tx_shift_r <= reload_byte_s;
                            miso_r     <= out_bit(reload_byte_s, lsbfe_r);
                            bit_cnt_r  <= 4'd0;
                        end else if (step_s) begin
                            tx_shift_r <= tx_next_s;
                            miso_r     <= out_bit(tx_next_s, lsbfe_r);
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    miso_r    <= 1'b0;
                    miso_oe_r <= 1'b0;
                    bit_cnt_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_slave_responder.md
# spi_slave_responder

SPI slave-side responder: the far end of the bus driven by the team's SPI master (which generates SS, SCLK and MOSI). It oversamples SS/SCLK/MOSI in the PCLK domain and shifts received bits into an 8-bit receive register. It shifts transmit bytes out on MISO from a single-entry transmit buffer and reports completion, overrun and underrun to the local APB-side register logic. It supports all four CPOL/CPHA modes and MSB- or LSB-first ordering.

## Interface
- SYNC_STAGES, 2: synchronizer flops on ss_n_i, sclk_i, mosi_i (minimum 2)
- PCLK  input  1  system clock; all logic on rising edge
- PRESET  input  1  synchronous, active-high reset
- spe_i  input  1  slave enable; 0 forces IDLE
- cpol_i, cpha_i  input  1 each  SPI mode; sampled only in IDLE
- lsbfe_i  input  1  1 = LSB first; sampled only in IDLE
- ss_n_i  input  1  slave select from bus, active low, asynchronous
- sclk_i  input  1  serial clock from bus, asynchronous
- mosi_i  input  1  serial data in, asynchronous
- miso_o  output  1  serial data out
- miso_oe_o  output  1  MISO drive enable; 1 only while selected
- tx_data_i  input  8  byte to transmit
- tx_load_i  input  1  write tx_data_i into the transmit buffer
- tx_ready_o  output  1  transmit buffer empty
- rx_data_o  output  8  last received byte
- rx_valid_o  output  1  rx_data_o holds an unread byte
- rx_ack_i  input  1  clears rx_valid_o
- overrun_o  output  1  sticky: byte completed while rx_valid_o=1
- underrun_o  output  1  sticky: shift register loaded while buffer empty
- status_clr_i  input  1  clears overrun_o and underrun_o
- busy_o  output  1  state is ACTIVE

## Operation
- Reset values: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=8'h00, rx_valid_o=0, overrun_o=0, underrun_o=0, busy_o=0, bit_cnt=0, state IDLE.
- Front end: ss_n_i, sclk_i and mosi_i each pass through SYNC_STAGES flops. One extra flop on synchronized SCLK provides edge detection.
- Leading edge: SCLK leaves cpol_i. Trailing edge: SCLK returns to cpol_i.
- Sample edge: leading if cpha_i=0, trailing if cpha_i=1. Shift edge: the other one.
- States:
  - IDLE -> ACTIVE when synchronized SS is low and spe_i=1.
  - ACTIVE -> IDLE when synchronized SS goes high or spe_i=0.
  - Mode bits are latched on the IDLE->ACTIVE transition.
- On IDLE->ACTIVE:
  - The shift register loads the buffer byte and the buffer empties (tx_ready_o=1).
  - If the buffer is empty, the shift register loads 8'h00 and underrun_o is set.
  - miso_oe_o=1; miso_o = bit 7, or bit 0 if lsbfe.
  - bit_cnt=0; first_shift flag set.
- Sample edge: the MOSI bit enters the rx shift register (MSB- or LSB-first per lsbfe) and bit_cnt increments.
- bit_cnt reaches 8:
  - If rx_valid_o=0: rx_data_o is updated and rx_valid_o is set.
  - If rx_valid_o=1: overrun_o is set and rx_data_o is not overwritten.
- Shift edge:
  - cpha_i=1 with first_shift set: no shift; first_shift clears.
  - bit_cnt=8: reload from the buffer (same empty/underrun rule as above); bit_cnt=0.
  - Otherwise: shift the tx register one position and present the next bit.
- Transmit buffer:
  - tx_load_i with tx_ready_o=1 stores tx_data_i and clears tx_ready_o.
  - tx_load_i with tx_ready_o=0 is ignored.
  - A load in the same cycle as a reload feeds the shift register with the new byte (the buffer stays empty).
- rx_ack_i clears rx_valid_o. If ack and completion coincide, completion wins: new data, rx_valid_o=1, no overrun.
- status_clr_i clears both sticky flags. A coincident set event wins.
- Abort (SS high or spe_i=0 mid-byte):
  - Partial rx bits are discarded; bit_cnt=0.
  - miso_oe_o=0, miso_o=0.
  - The buffer, rx_data_o and the flags are kept.
- A PRESET mid-transfer returns everything to reset values in the next cycle.

## Timing
- Pin to effect: a pin change acts SYNC_STAGES+1 PCLK cycles later (3 at default).
- rx_valid_o rises 1 cycle after the 8th sample edge is detected.
- miso_o changes 1 cycle after the shift edge is detected. miso_oe_o rises 1 cycle after synchronized SS low is seen.
- Requirements on the master:
  - Each SCLK half-period is at least SYNC_STAGES+2 PCLK cycles.
  - SS setup before the first SCLK edge is at least SYNC_STAGES+2 PCLK cycles.
- tx_ready_o rises in the cycle the shift register loads. A byte written within 1 cycle of tx_ready_o rising is used for the next reload.

## Test plan
- Mode 0, MSB first, tx 8'hA5 preloaded, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=8'h3C; rx_valid_o=1; tx_ready_o=1; no flags.
- Mode 3, lsbfe=1, tx 8'h81, master sends 8'h0F -> MISO LSB first (1,0,0,0,0,0,0,1); rx_data_o=8'h0F; first leading edge does not shift.
- Two back-to-back bytes under one SS low in mode 1, tx 8'h11 then 8'h22 loaded on tx_ready_o -> MISO carries 11,22; rx_ack_i after each byte; no overrun or underrun.
- Two bytes received without rx_ack_i -> rx_data_o holds the first byte, overrun_o=1; status_clr_i clears it.
- SS raised after 3 bits -> busy_o=0, miso_oe_o=0, rx_valid_o unchanged; next full byte receives correctly with bit_cnt restarted.
- SS asserted with tx buffer empty -> MISO all zeros, underrun_o=1; PRESET mid-byte -> all outputs return to reset values next cycle.
